// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master that turns one command into one AXI
// transaction and returns one response. Define AXIL_MASTER_TIMEOUT_EN to abort stalled transactions.
module axil_master #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,

    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,

    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t state;

    if (TIMEOUT_CYC < 1) begin : g_timeout_range
        $error("axil_master: TIMEOUT_CYC must be at least 1");
    end

    // NOTE: cmd_ready is decoded rather than registered so it falls in the very cycle reset rises.
    assign cmd_ready = (state == IDLE) && !reset;

    // A VALID stays up next cycle only if its handshake did not complete this cycle.
    logic aw_pending;
    logic w_pending;
    assign aw_pending = M_AXI_AWVALID && !M_AXI_AWREADY;
    assign w_pending  = M_AXI_WVALID  && !M_AXI_WREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] timer;
    logic          busy;
    logic          expired;
    assign busy    = (state == WADDR) || (state == WRESP) ||
                     (state == RADDR) || (state == RDATA);
    assign expired = busy && (timer == TW'(TIMEOUT_CYC - 1));
`endif

    // NOTE: every register here uses <= so all next-state terms read the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
            rsp_timeout   <= 1'b0;
            timer         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
`ifdef AXIL_MASTER_TIMEOUT_EN
                        timer <= '0;
`endif
                        if (cmd_write) begin
                            state         <= WADDR;
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= RADDR;
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                WADDR: begin
                    M_AXI_AWVALID <= aw_pending;
                    M_AXI_WVALID  <= w_pending;
                    if (!aw_pending && !w_pending) begin
                        state        <= WRESP;
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        state        <= DONE;
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= M_AXI_BRESP;
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        state         <= RDATA;
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        state        <= DONE;
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
            // Placed after the case so an abort overrides any progress made in the same cycle.
            if (busy) begin
                if (expired) begin
                    state         <= DONE;
                    M_AXI_AWVALID <= 1'b0;
                    M_AXI_WVALID  <= 1'b0;
                    M_AXI_BREADY  <= 1'b0;
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b0;
                    rsp_valid     <= 1'b1;
                    rsp_rdata     <= '0;
                    rsp_resp      <= 2'b10;
                    rsp_timeout   <= 1'b1;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
`endif
        end
    end

`ifndef AXIL_MASTER_TIMEOUT_EN
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master.sv
// Directed self-checking bench for axil_master; acts as the AXI slave by hand, cycle by cycle.
// The abort scenario runs only when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    int checks = 0;
    int errors = 0;

    axil_master #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_araddr", araddr, 0);
        reset = 1'b0;
        tick();
        check("idle_cmd_ready", cmd_ready, 1);

        // Write, slave ready immediately
        awready = 1'b1; wready = 1'b1;
        issue(1'b1, 32'h0000_0000, 32'h0000_0002);
        check("w1_awvalid", awvalid, 1);
        check("w1_wvalid", wvalid, 1);
        check("w1_cmd_ready", cmd_ready, 0);
        check("w1_awaddr", awaddr, 32'h0);
        check("w1_wdata", wdata, 32'h2);
        check("w1_wstrb", wstrb, 4'hF);
        tick();
        awready = 1'b0; wready = 1'b0;
        check("w1_awvalid_drop", awvalid, 0);
        check("w1_wvalid_drop", wvalid, 0);
        check("w1_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check("w1_rsp_valid", rsp_valid, 1);
        check("w1_rsp_resp", rsp_resp, 0);
        check("w1_rsp_rdata", rsp_rdata, 0);
        check("w1_bready_drop", bready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("w1_rsp_valid_clr", rsp_valid, 0);
        check("w1_cmd_ready_back", cmd_ready, 1);

        // Write, W accepted three cycles before AW
        wready = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("w2_both_valid", {awvalid, wvalid}, 2'b11);
        tick();
        wready = 1'b0;
        check("w2_wvalid_first", wvalid, 0);
        check("w2_awvalid_held0", awvalid, 1);
        tick();
        check("w2_awvalid_held1", awvalid, 1);
        check("w2_bready_wait", bready, 0);
        tick();
        check("w2_awvalid_held2", awvalid, 1);
        check("w2_awaddr_stable", awaddr, 32'h10);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("w2_awvalid_drop", awvalid, 0);
        check("w2_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        check("w2_rsp_valid", rsp_valid, 1);
        check("w2_rsp_resp", rsp_resp, 0);
        check("w2_bready_drop", bready, 0);
        // B held high in DONE is ignored: a second response must not appear
        bresp = 2'b11;
        rsp_ready = 1'b1;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        rsp_ready = 1'b0;
        check("w2_single_b", rsp_valid, 0);
        check("w2_resp_kept", rsp_resp, 0);

        // Read, ARREADY after two cycles; a stray R beat in RADDR is ignored
        issue(1'b0, 32'h0000_0010, 32'h0);
        check("r1_arvalid", arvalid, 1);
        check("r1_araddr", araddr, 32'h10);
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b11;
        check("r1_rready_low", rready, 0);
        tick();
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        check("r1_arvalid_held", arvalid, 1);
        tick();
        check("r1_arvalid_held2", arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("r1_arvalid_drop", arvalid, 0);
        check("r1_rready", rready, 1);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = '0;
        check("r1_rsp_valid", rsp_valid, 1);
        check("r1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("r1_rsp_resp", rsp_resp, 0);
        check("r1_rready_drop", rready, 0);

        // Response held while rsp_ready stays low for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_rsp_valid", i), rsp_valid, 1);
            check($sformatf("hold%0d_rsp_rdata", i), rsp_rdata, 32'hDEAD_BEEF);
            check($sformatf("hold%0d_cmd_ready", i), cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hold_rsp_valid_clr", rsp_valid, 0);
        check("hold_cmd_ready_back", cmd_ready, 1);

        // Read with SLVERR forwarded unchanged
        arready = 1'b1;
        issue(1'b0, 32'h0000_0020, 32'h0);
        tick();
        arready = 1'b0;
        check("r2_rready", rready, 1);
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        check("r2_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("r2_rsp_resp", rsp_resp, 2'b10);
        check("r2_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset pulsed while ARVALID waits
        issue(1'b0, 32'h0000_0030, 32'h0);
        tick();
        check("rr_arvalid_wait", arvalid, 1);
        reset = 1'b1;
        tick();
        check("rr_arvalid_drop", arvalid, 0);
        check("rr_rsp_valid", rsp_valid, 0);
        check("rr_cmd_ready_in_reset", cmd_ready, 0);
        check("rr_araddr", araddr, 0);
        reset = 1'b0;
        #1;
        check("rr_cmd_ready_release", cmd_ready, 1);
        tick();
        check("rr_no_rsp", rsp_valid, 0);
        check("rr_arvalid_idle", arvalid, 0);

`ifdef AXIL_MASTER_TIMEOUT_EN
        // Read with ARREADY never asserted aborts after 16 busy cycles
        issue(1'b0, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        check("to_arvalid_before", arvalid, 1);
        check("to_rsp_valid_before", rsp_valid, 0);
        tick();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_resp", rsp_resp, 2'b10);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_arvalid_drop", arvalid, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("to_timeout_clr", rsp_timeout, 0);
        check("to_cmd_ready", cmd_ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 1024, cycles allowed per outstanding transaction before abort (used only with AXIL_MASTER_TIMEOUT_EN).
REQ-002 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_addr in 32, cmd_wdata in 32, cmd_wstrb in 4.
REQ-005 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_resp out 2, rsp_timeout out 1.
REQ-006 SHALL have write channel ports: M_AXI_AWADDR out 32, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-007 SHALL have ports: M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-008 SHALL have read channel ports: M_AXI_ARADDR out 32, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-009 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, DONE; one transaction outstanding at most.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; command accepted on cmd_valid&cmd_ready, addr/wdata/wstrb registered at acceptance.
REQ-011 SHALL, on accepted write, enter WADDR and assert AWVALID and WVALID together the following cycle (1-cycle latency).
REQ-012 SHALL drop AWVALID the cycle after AWVALID&AWREADY and WVALID the cycle after WVALID&WREADY, independently; AW-before-W, W-before-AW and same-cycle handshakes all legal.
REQ-013 SHALL hold AWADDR/WDATA/WSTRB stable while the corresponding VALID is high; VALID never withdrawn before handshake.
REQ-014 SHALL enter WRESP once both AW and W handshakes are done, asserting BREADY=1; on BVALID&BREADY capture BRESP into rsp_resp, rsp_rdata=0, enter DONE.
REQ-015 SHALL, on accepted read, enter RADDR and assert ARVALID next cycle; on ARVALID&ARREADY enter RDATA with RREADY=1.
REQ-016 SHALL, on RVALID&RREADY, capture RDATA/RRESP into rsp_rdata/rsp_resp, enter DONE.
REQ-017 SHALL hold rsp_valid=1 and response fields stable in DONE until rsp_ready; return to IDLE the cycle after rsp_valid&rsp_ready.
REQ-018 SHALL ignore BVALID/RVALID outside WRESP/RDATA (BREADY/RREADY low there).
REQ-019 SHALL forward non-OKAY responses (01/10/11) unchanged; no retries.
REQ-020 SHALL keep rsp_timeout=0 for all normally completed transactions.

Reset
REQ-021 SHALL on reset go to IDLE and drive AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout = 0; rsp_rdata = 0, rsp_resp = 00; AXI address/data outputs = 0.
REQ-022 SHALL, when reset asserts mid-transaction, abandon it and drop all VALID/READY outputs the next edge, producing no response.
REQ-023 SHALL drive cmd_ready=0 during reset-high cycles.

Configuration
REQ-024 SHALL, with AXIL_MASTER_TIMEOUT_EN defined, count cycles in WADDR/WRESP/RADDR/RDATA (cleared at acceptance); at count==TIMEOUT_CYC drop all AXI VALID/READY, set rsp_resp=10, rsp_rdata=0, rsp_timeout=1, enter DONE.
REQ-025 SHALL, without AXIL_MASTER_TIMEOUT_EN, contain no counter, tie rsp_timeout=0, and wait indefinitely for handshakes.

Verification
REQ-026 SHALL cover: write addr 0x000 data 0x00000002 strb F, slave AWREADY=WREADY=1 immediately, BRESP=00 -> AWVALID/WVALID high 1 cycle, rsp_valid with rsp_resp=00.
REQ-027 SHALL cover: write addr 0x010 data 0xDEADBEEF, WREADY 3 cycles before AWREADY -> WVALID drops first, AWVALID held, single B response accepted, rsp_resp=00.
REQ-028 SHALL cover: read addr 0x010, ARREADY after 2 cycles, RVALID with RDATA=0xDEADBEEF RRESP=00 -> rsp_rdata=0xDEADBEEF, rsp_resp=00.
REQ-029 SHALL cover: rsp_ready held low 5 cycles after completion -> rsp_valid and fields stable 5 cycles, cmd_ready=0 until handshake.
REQ-030 SHALL cover: reset pulsed while ARVALID=1 waiting -> ARVALID=0 next cycle, no rsp_valid, cmd_ready=1 after release.
REQ-031 SHALL cover (AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYC=16): read with ARREADY never asserted -> after 16 cycles rsp_valid=1, rsp_resp=10, rsp_timeout=1, ARVALID=0.
